// File: rtl/reg_wr_arbiter.sv
// Write-port arbiter for an 8x8 register file: two round-robin requesters plus a clear walk.
// Optional REG_WR_ARB_STALL_CNT_EN adds saturating per-requester stall counters (STALL0/STALL1).
module reg_wr_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VALID0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              READY0,
  input  logic              VALID1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              READY1,
  input  logic              CLR_REQ,
  output logic              BUSY,
  output logic              CLR_DONE,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN
`ifdef REG_WR_ARB_STALL_CNT_EN
  ,
  output logic [7:0]        STALL0,
  output logic [7:0]        STALL1
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, CLR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_reg;
  logic [ADDR_W-1:0]   count_reg;
  logic                rr_last_reg;
  logic                write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                clr_done_reg;
  logic                grant_ok;

  // Grants are a pure function of state and inputs, never of each other.
  assign grant_ok = RESET && (state_reg == IDLE) && !CLR_REQ;
  assign READY0   = grant_ok && VALID0 && (!VALID1 || rr_last_reg);
  assign READY1   = grant_ok && VALID1 && (!VALID0 || !rr_last_reg);

  assign BUSY      = (state_reg == CLR);
  assign CLR_DONE  = clr_done_reg;
  assign WRITE     = write_reg;
  assign INADDRESS = addr_reg;
  assign IN        = data_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      rr_last_reg  <= 1'b1;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      clr_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (CLR_REQ) begin
            state_reg <= CLR;
            count_reg <= '0;
            write_reg <= 1'b0;
          end else if (VALID0 && READY0) begin
            write_reg   <= 1'b1;
            addr_reg    <= ADDR0;
            data_reg    <= DATA0;
            rr_last_reg <= 1'b0;
          end else if (VALID1 && READY1) begin
            write_reg   <= 1'b1;
            addr_reg    <= ADDR1;
            data_reg    <= DATA1;
            rr_last_reg <= 1'b1;
          end else begin
            write_reg <= 1'b0;
          end
        end
        CLR: begin
          write_reg <= 1'b1;
          addr_reg  <= count_reg;
          data_reg  <= CLR_VALUE;
          count_reg <= count_reg + ADDR_ONE;
          // The done pulse lines up with the last clear write on the outputs.
          if (count_reg == LAST_ADDR) begin
            state_reg    <= IDLE;
            clr_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef REG_WR_ARB_STALL_CNT_EN
  logic [7:0] stall0_reg;
  logic [7:0] stall1_reg;

  assign STALL0 = stall0_reg;
  assign STALL1 = stall1_reg;

  // Counters survive the clear sequence; only reset zeroes them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall0_reg <= 8'd0;
      stall1_reg <= 8'd0;
    end else begin
      if (VALID0 && !READY0 && (stall0_reg != 8'hFF))
        stall0_reg <= stall0_reg + 8'd1;
      if (VALID1 && !READY1 && (stall1_reg != 8'hFF))
        stall1_reg <= stall1_reg + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed self-checking bench for reg_wr_arbiter; one task per scenario.
// Define REG_WR_ARB_STALL_CNT_EN to also exercise the stall counters.
module tb_reg_wr_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       VALID0 = 1'b0, VALID1 = 1'b0, CLR_REQ = 1'b0;
  logic [2:0] ADDR0 = '0, ADDR1 = '0;
  logic [7:0] DATA0 = '0, DATA1 = '0;
  logic       READY0, READY1, BUSY, CLR_DONE, WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
`ifdef REG_WR_ARB_STALL_CNT_EN
  logic [7:0] STALL0, STALL1;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] rf [8];

  reg_wr_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .VALID0(VALID0), .ADDR0(ADDR0), .DATA0(DATA0), .READY0(READY0),
    .VALID1(VALID1), .ADDR1(ADDR1), .DATA1(DATA1), .READY1(READY1),
    .CLR_REQ(CLR_REQ), .BUSY(BUSY), .CLR_DONE(CLR_DONE),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN)
`ifdef REG_WR_ARB_STALL_CNT_EN
    , .STALL0(STALL0), .STALL1(STALL1)
`endif
  );

  always #5 CLK = ~CLK;

  // Register file fed by the arbiter outputs.
  always @(posedge CLK) if (WRITE) rf[INADDRESS] <= IN;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    VALID0 = 1'b0; VALID1 = 1'b0; CLR_REQ = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    VALID0 = 1'b1; ADDR0 = 3'd2; DATA0 = 8'd95;
    tick();
    checks++;
    if ({WRITE, INADDRESS, IN, BUSY, CLR_DONE, READY0, READY1} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got W=%0b A=%0d D=%0d B=%0b CD=%0b R0=%0b R1=%0b exp all 0",
               WRITE, INADDRESS, IN, BUSY, CLR_DONE, READY0, READY1);
    end
  endtask

  task automatic test_single_write();
    RESET = 1'b1;
    #1;
    checks++;
    if (READY0 !== 1'b1 || READY1 !== 1'b0) begin
      failures++; $display("FAIL single_ready got R0=%0b R1=%0b exp R0=1 R1=0", READY0, READY1);
    end
    tick();
    VALID0 = 1'b0;
    checks++;
    if (WRITE !== 1'b1 || INADDRESS !== 3'd2 || IN !== 8'd95) begin
      failures++; $display("FAIL single_write got W=%0b A=%0d D=%0d exp W=1 A=2 D=95", WRITE, INADDRESS, IN);
    end
    tick();
    checks++;
    if (rf[2] !== 8'd95 || WRITE !== 1'b0) begin
      failures++; $display("FAIL single_commit got rf2=%0d W=%0b exp rf2=95 W=0", rf[2], WRITE);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    VALID0 = 1'b1; ADDR0 = 3'd1; DATA0 = 8'd28;
    VALID1 = 1'b1; ADDR1 = 3'd4; DATA1 = 8'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (READY0 !== (i % 2 == 0) || READY1 !== (i % 2 == 1)) begin
        failures++; $display("FAIL rr_grant_%0d got R0=%0b R1=%0b exp grant %0d", i, READY0, READY1, i % 2);
      end
      tick();
      checks++;
      if (WRITE !== 1'b1 || INADDRESS !== ((i % 2 == 0) ? 3'd1 : 3'd4) ||
          IN !== ((i % 2 == 0) ? 8'd28 : 8'd6)) begin
        failures++; $display("FAIL rr_write_%0d got W=%0b A=%0d D=%0d", i, WRITE, INADDRESS, IN);
      end
    end
    VALID0 = 1'b0; VALID1 = 1'b0;
    tick();
    checks++;
    if (WRITE !== 1'b0) begin
      failures++; $display("FAIL rr_idle got W=%0b exp 0", WRITE);
    end
  endtask

  task automatic test_clear();
    do_reset();
    VALID1 = 1'b1; ADDR1 = 3'd5; DATA1 = 8'd77;
    CLR_REQ = 1'b1;
    #1;
    checks++;
    if (READY1 !== 1'b0 || READY0 !== 1'b0) begin
      failures++; $display("FAIL clr_req_block got R1=%0b exp 0", READY1);
    end
    tick();
    CLR_REQ = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (READY1 !== 1'b0 || BUSY !== 1'b1) begin
        failures++; $display("FAIL clr_busy_%0d got R1=%0b B=%0b exp R1=0 B=1", i, READY1, BUSY);
      end
      tick();
      checks++;
      if (WRITE !== 1'b1 || INADDRESS !== 3'(i) || IN !== 8'h00 || CLR_DONE !== (i == 7)) begin
        failures++; $display("FAIL clr_write_%0d got W=%0b A=%0d D=%0d CD=%0b exp A=%0d D=0",
                             i, WRITE, INADDRESS, IN, CLR_DONE, i);
      end
    end
    #1;
    checks++;
    if (BUSY !== 1'b0 || READY1 !== 1'b1) begin
      failures++; $display("FAIL clr_return got B=%0b R1=%0b exp B=0 R1=1", BUSY, READY1);
    end
    tick();
    VALID1 = 1'b0;
    checks++;
    if (WRITE !== 1'b1 || INADDRESS !== 3'd5 || IN !== 8'd77 || CLR_DONE !== 1'b0) begin
      failures++; $display("FAIL clr_served got W=%0b A=%0d D=%0d CD=%0b exp W=1 A=5 D=77 CD=0",
                           WRITE, INADDRESS, IN, CLR_DONE);
    end
  endtask

  task automatic test_reset_mid_clear();
    int done_seen;
    int wait_cnt;
    do_reset();
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    wait_cnt = 0;
    while (INADDRESS !== 3'd3 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (INADDRESS !== 3'd3 || WRITE !== 1'b1) begin
      failures++; $display("FAIL midclr_reach got A=%0d W=%0b exp A=3 W=1", INADDRESS, WRITE);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (WRITE !== 1'b0 || BUSY !== 1'b0 || CLR_DONE !== 1'b0 || INADDRESS !== 3'd0) begin
      failures++; $display("FAIL midclr_abort got W=%0b B=%0b CD=%0b A=%0d exp all 0",
                           WRITE, BUSY, CLR_DONE, INADDRESS);
    end
    tick();
    RESET = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CLR_DONE !== 1'b0 || BUSY !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++; $display("FAIL midclr_after got %0d busy/done cycles exp 0", done_seen);
    end
  endtask

  task automatic test_toggle();
    logic v0_tab [8];
    logic g_tab  [8];
    v0_tab = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    g_tab  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    ADDR0 = 3'd3; DATA0 = 8'd33;
    ADDR1 = 3'd7; DATA1 = 8'hA5;
    VALID1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      VALID0 = v0_tab[i];
      #1;
      checks++;
      if (READY0 !== !g_tab[i] || READY1 !== g_tab[i]) begin
        failures++; $display("FAIL tog_grant_%0d got R0=%0b R1=%0b exp grant %0d", i, READY0, READY1, g_tab[i]);
      end
      tick();
      checks++;
      if (WRITE !== 1'b1 || INADDRESS !== (g_tab[i] ? 3'd7 : 3'd3) || IN !== (g_tab[i] ? 8'hA5 : 8'd33)) begin
        failures++; $display("FAIL tog_write_%0d got W=%0b A=%0d D=%0d", i, WRITE, INADDRESS, IN);
      end
    end
    VALID0 = 1'b0; VALID1 = 1'b0;
    tick();
  endtask

`ifdef REG_WR_ARB_STALL_CNT_EN
  task automatic test_stall_count();
    do_reset();
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    VALID1 = 1'b1; ADDR1 = 3'd2; DATA1 = 8'd9;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (STALL1 !== 8'd8 || STALL0 !== 8'd0) begin
      failures++; $display("FAIL stall_clear got S1=%0d S0=%0d exp S1=8 S0=0", STALL1, STALL0);
    end
    CLR_REQ = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (STALL1 !== 8'hFF) begin
      failures++; $display("FAIL stall_sat got S1=%0d exp 255", STALL1);
    end
    tick();
    tick();
    checks++;
    if (STALL1 !== 8'hFF) begin
      failures++; $display("FAIL stall_hold got S1=%0d exp 255", STALL1);
    end
    CLR_REQ = 1'b0; VALID1 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear();
    test_reset_mid_clear();
    test_toggle();
`ifdef REG_WR_ARB_STALL_CNT_EN
    test_stall_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Owns the single write port of the 8x8-bit register file.
- Shares that port between two requesters: requester 0 (CPU writeback) and requester 1 (loader/debug). Uses valid/ready handshakes and round-robin arbitration on conflict.
- Also runs a clear sequence that walks all registers and writes CLR_VALUE, one per cycle.
- Its registered outputs drive the register file's WRITE, INADDRESS and IN inputs directly.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width; register count = 2**ADDR_W.
- CLR_VALUE, 8'h00, value written to every register during the clear sequence.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- VALID0  input  1  requester 0 has a write pending.
- ADDR0  input  ADDR_W  requester 0 target register.
- DATA0  input  DATA_W  requester 0 write data.
- READY0  output  1  requester 0 write accepted this cycle (combinational).
- VALID1  input  1  requester 1 has a write pending.
- ADDR1  input  ADDR_W  requester 1 target register.
- DATA1  input  DATA_W  requester 1 write data.
- READY1  output  1  requester 1 write accepted this cycle (combinational).
- CLR_REQ  input  1  start clear sequence (level, sampled in IDLE).
- BUSY  output  1  clear sequence in progress.
- CLR_DONE  output  1  one-cycle pulse after the last clear write.
- WRITE  output  1  register file write enable (registered).
- INADDRESS  output  ADDR_W  register file write address (registered).
- IN  output  DATA_W  register file write data (registered).

Behaviour:
- Reset (RESET low, asynchronous):
  - State = IDLE; clear counter = 0; rr_last = 1, so requester 0 wins the first tie.
  - Outputs: WRITE=0, INADDRESS=0, IN=0, BUSY=0, CLR_DONE=0, READY0=0, READY1=0.
  - Reset during CLR aborts the sequence immediately; no CLR_DONE is generated.
- Two states: IDLE and CLR.
- IDLE, priority order:
  - CLR_REQ high: takes precedence over any request. READY0=READY1=0; next state CLR, counter=0.
  - Otherwise, only VALID0 high: READY0=1.
  - Otherwise, only VALID1 high: READY1=1.
  - Both high: grant the requester that is not rr_last.
  - At most one READY is high in any cycle. READY never depends on READY, so there is no combinational loop.
- Handshake:
  - A transfer occurs at a posedge where VALIDn && READYn.
  - Requester must hold VALIDn/ADDRn/DATAn stable until accepted.
  - On transfer: WRITE<=1, INADDRESS<=ADDRn, IN<=DATAn, rr_last<=n.
  - With no transfer in IDLE: WRITE<=0; INADDRESS and IN hold their values.
- Latency and throughput:
  - Accepted at edge k → WRITE high during cycle k..k+1 → register file commits at edge k+1.
  - Back-to-back accepts are allowed: one write per cycle.
- CLR state:
  - Each cycle: WRITE<=1, INADDRESS<=counter, IN<=CLR_VALUE, counter<=counter+1.
  - BUSY=1 throughout CLR; READY0=READY1=0.
  - After emitting address 2**ADDR_W-1, the counter wraps to 0 and the state returns to IDLE. CLR_DONE pulses in the cycle the last write is presented.
  - CLR_REQ is ignored while in CLR.
  - Total: exactly 2**ADDR_W consecutive WRITE cycles, addresses ascending 0..7.
- Requests during CLR stall and are served in round-robin order after return to IDLE. CLR_REQ still high on return to IDLE restarts the clear.
- Address and data pass through unmodified; no width conversion.

Optional Feature:
- Macro: REG_WR_ARB_STALL_CNT_EN.
- Defined: adds output ports STALL0 and STALL1, each 8 bits. Counter n increments at every posedge where VALIDn && !READYn and saturates at 8'hFF. Both counters reset to 0 and are not cleared by the clear sequence.
- Undefined: ports and counters are absent; arbitration and timing are identical.

Test Plan:
- Reset release, VALID0=1, ADDR0=2, DATA0=95 → READY0=1 same cycle; next cycle WRITE=1, INADDRESS=2, IN=95; register 2 reads 95 after the following edge.
- VALID0 and VALID1 both held for 4 cycles (ADDR0=1/DATA0=28, ADDR1=4/DATA1=6) → grants alternate 0,1,0,1; WRITE high 4 consecutive cycles; no cycle with READY0 and READY1 both high.
- CLR_REQ pulse in IDLE with VALID1 also high → READY1=0 for 8 cycles; INADDRESS runs 0..7 with IN=0; CLR_DONE pulses once with address 7; then requester 1 is accepted.
- Reset asserted mid-clear at address 3 → WRITE, BUSY and CLR_DONE drop to 0 immediately; after release state is IDLE and no CLR_DONE pulse occurs.
- VALID0 toggling while VALID1 held → every cycle writes exactly one requester; requester 1 is never starved more than 1 cycle.
- REG_WR_ARB_STALL_CNT_EN defined: VALID1 held through a full clear (8 cycles) → STALL1 = 8; 300 stalled cycles → STALL1 = 255 and holds.
